// File: rtl/pipe_tx_scrambler.sv
// pipe_tx_scrambler: per-lane PIPE transmit scrambler.
// Gen1/2 use a 16-bit LFSR (one byte per cycle, COM/SKP aware); Gen3 uses a
// 23-bit LFSR with a block-type FSM (two bytes per cycle).
// Optional feature macro: SCRAMBLER_BYPASS_EN adds scrambleDisable, which
// passes data through unscrambled while the LFSR keeps tracking the link.
module pipe_tx_scrambler #(
    parameter logic [23:0] LANE_SEED            = 24'h1DBFBC,
    parameter logic [15:0] GEN12_SEED           = 16'hFFFF,
    parameter int          GEN3_WORDS_PER_BLOCK = 8
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic [2:0]  generation,
    input  logic [31:0] inData,
    input  logic [3:0]  inDataK,
    input  logic [1:0]  inSyncHeader,
    input  logic        inBlockStart,
    input  logic        inDataValid,
`ifdef SCRAMBLER_BYPASS_EN
    input  logic        scrambleDisable,
`endif
    output logic [31:0] scramblerDataOut,
    output logic [3:0]  scramblerDataK,
    output logic [1:0]  scramblerSyncHeader,
    output logic        scramblerDataValid
);

    localparam int              WC_W    = (GEN3_WORDS_PER_BLOCK > 1) ? $clog2(GEN3_WORDS_PER_BLOCK) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(GEN3_WORDS_PER_BLOCK - 1);
    localparam logic [22:0]     SEED23  = LANE_SEED[22:0];
    localparam logic [22:0]     TAPS23  = 23'h210125;
    localparam logic [15:0]     TAPS16  = 16'h0039;
    localparam logic [7:0]      SYM_COM     = 8'hBC;
    localparam logic [7:0]      SYM_SKP     = 8'h1C;
    localparam logic [7:0]      SYM_SKP_END = 8'hE1;
    localparam logic [7:0]      ID_EIEOS    = 8'h00;
    localparam logic [7:0]      ID_SKP      = 8'hAA;

    typedef enum logic [2:0] {
        WAIT_BLK,
        DATA_BLK,
        OS_BLK,
        SKP_BLK,
        EIEOS_BLK
    } blk_state_t;

    // Galois step of x^16+x^5+x^4+x^3+1 over one byte: {keystream byte, next LFSR}.
    function automatic logic [23:0] step16(input logic [15:0] l);
        logic [15:0] s;
        logic [7:0]  ks;
        logic        b;
        s  = l;
        ks = '0;
        for (int i = 0; i < 8; i++) begin
            b     = s[15];
            ks[i] = b;
            s     = {s[14:0], 1'b0} ^ (b ? TAPS16 : 16'h0000);
        end
        return {ks, s};
    endfunction

    // Galois step of x^23+x^21+x^16+x^8+x^5+x^2+1 over one byte: {keystream byte, next LFSR}.
    function automatic logic [30:0] step23(input logic [22:0] l);
        logic [22:0] s;
        logic [7:0]  ks;
        logic        b;
        s  = l;
        ks = '0;
        for (int i = 0; i < 8; i++) begin
            b     = s[22];
            ks[i] = b;
            s     = {s[21:0], 1'b0} ^ (b ? TAPS23 : 23'h000000);
        end
        return {ks, s};
    endfunction

    logic            scr_en;
    logic            unused_bits;
    logic [2:0]      prev_gen;
    logic [15:0]     lfsr16, lfsr16_nxt, l16;
    logic [22:0]     lfsr23, lfsr23_nxt, l23;
    blk_state_t      state, state_nxt, cur_state, blk;
    logic [WC_W-1:0] word_cnt, wc_nxt, cur_wc, idx;
    logic            gen_change, blk_last;
    logic [23:0]     r16;
    logic [30:0]     r23a, r23b;
    logic [7:0]      ks_a, ks_b;
    logic [31:0]     data_p0;
    logic [3:0]      k_p0;
    logic [1:0]      sh_p0;
    logic            vld_p0;

`ifdef SCRAMBLER_BYPASS_EN
    assign scr_en = ~scrambleDisable;
`else
    assign scr_en = 1'b1;
`endif

    // Upper symbol lanes are never used by this scrambler.
    assign unused_bits = ^{inDataK[3:1], inData[31:16]};

    // Next-state, LFSR update and stage-0 output data for the current input word.
    always_comb begin
        gen_change = (generation != prev_gen);
        l16        = gen_change ? GEN12_SEED : lfsr16;
        l23        = gen_change ? SEED23 : lfsr23;
        cur_state  = gen_change ? WAIT_BLK : state;
        cur_wc     = gen_change ? '0 : word_cnt;

        lfsr16_nxt = l16;
        lfsr23_nxt = l23;
        state_nxt  = cur_state;
        wc_nxt     = cur_wc;
        data_p0    = '0;
        k_p0       = '0;
        sh_p0      = scramblerSyncHeader;
        vld_p0     = 1'b0;
        blk        = WAIT_BLK;
        idx        = '0;
        blk_last   = 1'b0;
        r16        = '0;
        r23a       = '0;
        r23b       = '0;
        ks_a       = '0;
        ks_b       = '0;

        case (generation)
            3'd1, 3'd2: begin
                state_nxt = WAIT_BLK;
                wc_nxt    = '0;
                if (inDataValid) begin
                    vld_p0  = 1'b1;
                    k_p0[0] = inDataK[0];
                    r16     = step16(l16);
                    if (inDataK[0]) begin
                        data_p0[7:0] = inData[7:0];
                        if (inData[7:0] == SYM_COM)
                            lfsr16_nxt = GEN12_SEED;
                        else if (inData[7:0] != SYM_SKP)
                            lfsr16_nxt = r16[15:0];
                    end else begin
                        data_p0[7:0] = inData[7:0] ^ (r16[23:16] & {8{scr_en}});
                        lfsr16_nxt   = r16[15:0];
                    end
                end
            end
            3'd3: begin
                if (inDataValid) begin
                    vld_p0 = 1'b1;
                    if (inBlockStart) begin
                        // An abandoned EIEOS block still owes its LFSR reload.
                        if (cur_state == EIEOS_BLK)
                            l23 = SEED23;
                        sh_p0 = inSyncHeader;
                        if (inSyncHeader == 2'b10)
                            blk = DATA_BLK;
                        else if (inSyncHeader == 2'b01) begin
                            if (inData[7:0] == ID_EIEOS)
                                blk = EIEOS_BLK;
                            else if (inData[7:0] == ID_SKP)
                                blk = SKP_BLK;
                            else
                                blk = OS_BLK;
                        end else
                            blk = WAIT_BLK;
                    end else begin
                        blk = cur_state;
                        idx = cur_wc;
                    end

                    r23a          = step23(l23);
                    r23b          = step23(r23a[22:0]);
                    ks_a          = r23a[30:23] & {8{scr_en}};
                    ks_b          = r23b[30:23] & {8{scr_en}};
                    data_p0[15:0] = inData[15:0];
                    lfsr23_nxt    = l23;

                    case (blk)
                        DATA_BLK: begin
                            data_p0[15:0] = inData[15:0] ^ {ks_b, ks_a};
                            lfsr23_nxt    = r23b[22:0];
                        end
                        OS_BLK: begin
                            data_p0[15:0] = inData[15:0] ^ {ks_b, (idx == '0) ? 8'h00 : ks_a};
                            lfsr23_nxt    = r23b[22:0];
                        end
                        default: ;
                    endcase

                    if (blk == WAIT_BLK) begin
                        state_nxt = WAIT_BLK;
                        wc_nxt    = '0;
                    end else begin
                        blk_last = (idx == WC_LAST) ||
                                   ((blk == SKP_BLK) &&
                                    ((inData[7:0] == SYM_SKP_END) || (inData[15:8] == SYM_SKP_END)));
                        if (blk_last) begin
                            state_nxt = WAIT_BLK;
                            wc_nxt    = '0;
                            if (blk == EIEOS_BLK)
                                lfsr23_nxt = SEED23;
                        end else begin
                            state_nxt = blk;
                            wc_nxt    = idx + 1'b1;
                        end
                    end
                end
            end
            default: begin
                lfsr16_nxt = GEN12_SEED;
                lfsr23_nxt = SEED23;
                state_nxt  = WAIT_BLK;
                wc_nxt     = '0;
                sh_p0      = 2'b00;
            end
        endcase
    end

    // Block FSM, word counter, LFSRs and generation tracking.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state    <= WAIT_BLK;
            word_cnt <= '0;
            lfsr16   <= GEN12_SEED;
            lfsr23   <= SEED23;
            prev_gen <= 3'd0;
        end else begin
            state    <= state_nxt;
            word_cnt <= wc_nxt;
            lfsr16   <= lfsr16_nxt;
            lfsr23   <= lfsr23_nxt;
            prev_gen <= generation;
        end
    end

    // Stage 0 -> registered PIPE output bus (one pclk latency).
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            scramblerDataOut    <= '0;
            scramblerDataK      <= '0;
            scramblerSyncHeader <= '0;
            scramblerDataValid  <= 1'b0;
        end else begin
            scramblerDataOut    <= data_p0;
            scramblerDataK      <= k_p0;
            scramblerSyncHeader <= sh_p0;
            scramblerDataValid  <= vld_p0;
        end
    end

endmodule

// File: tb/tb_pipe_tx_scrambler.sv
// Directed bench for pipe_tx_scrambler: Gen1 COM/SKP handling, Gen3 block
// types, mid-block restart, idle generation and asynchronous reset.
module tb_pipe_tx_scrambler;

    localparam logic [22:0] SEED = 23'h1DBFBC;

    logic        pclk;
    logic        reset;
    logic [2:0]  generation;
    logic [31:0] inData;
    logic [3:0]  inDataK;
    logic [1:0]  inSyncHeader;
    logic        inBlockStart;
    logic        inDataValid;
    logic [31:0] scramblerDataOut;
    logic [3:0]  scramblerDataK;
    logic [1:0]  scramblerSyncHeader;
    logic        scramblerDataValid;
`ifdef SCRAMBLER_BYPASS_EN
    logic        scramble_disable = 1'b0;
`endif

    int          tests = 0;
    int          fails = 0;
    logic [22:0] m23;

    pipe_tx_scrambler dut (
        .pclk                (pclk),
        .reset               (reset),
        .generation          (generation),
        .inData              (inData),
        .inDataK             (inDataK),
        .inSyncHeader        (inSyncHeader),
        .inBlockStart        (inBlockStart),
        .inDataValid         (inDataValid),
`ifdef SCRAMBLER_BYPASS_EN
        .scrambleDisable     (scramble_disable),
`endif
        .scramblerDataOut    (scramblerDataOut),
        .scramblerDataK      (scramblerDataK),
        .scramblerSyncHeader (scramblerSyncHeader),
        .scramblerDataValid  (scramblerDataValid)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Reference Gen3 LFSR, written tap by tap: {keystream byte, next state}.
    function automatic logic [30:0] m3_byte(input logic [22:0] l);
        logic [22:0] s;
        logic [7:0]  ks;
        logic        b;
        s  = l;
        ks = '0;
        for (int i = 0; i < 8; i++) begin
            b      = s[22];
            ks[i]  = b;
            s      = {s[21:0], b};
            s[2]   = s[2]  ^ b;
            s[5]   = s[5]  ^ b;
            s[8]   = s[8]  ^ b;
            s[16]  = s[16] ^ b;
            s[21]  = s[21] ^ b;
        end
        return {ks, s};
    endfunction

    // Expected scrambled Gen3 word; keep0 leaves byte 0 clear (OS start word).
    task automatic m3_word(input logic [15:0] d, input logic keep0, output logic [15:0] e);
        logic [30:0] r;
        r       = m3_byte(m23);
        e[7:0]  = keep0 ? d[7:0] : (d[7:0] ^ r[30:23]);
        m23     = r[22:0];
        r       = m3_byte(m23);
        e[15:8] = d[15:8] ^ r[30:23];
        m23     = r[22:0];
    endtask

    // Present one input word and move to just after the capturing edge.
    task automatic step(input logic v, input logic [3:0] k, input logic [31:0] d,
                        input logic bs, input logic [1:0] sh);
        inDataValid  = v;
        inDataK      = k;
        inData       = d;
        inBlockStart = bs;
        inSyncHeader = sh;
        @(posedge pclk);
        #1;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        generation = 3'd0;
        step(1'b0, 4'h0, 32'h0, 1'b0, 2'b00);
        tests++;
        if ({scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut} !== 39'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %h want %h",
                     {scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut}, 39'h0);
        end
        reset = 1'b0;
        step(1'b0, 4'h0, 32'h0, 1'b0, 2'b00);
        tests++;
        if ({scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut} !== 39'h0) begin
            fails++;
            $display("FAIL post_reset_idle: got %h want %h",
                     {scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut}, 39'h0);
        end
    endtask

    task automatic test_gen1_com();
        logic        vi [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [3:0]  ki [7] = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hE};
        logic [31:0] di [7] = '{32'hBC, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h12345600};
        logic [38:0] ex [7] = '{{1'b1, 2'b00, 4'h1, 32'h000000BC},
                                {1'b1, 2'b00, 4'h0, 32'h000000FF},
                                {1'b1, 2'b00, 4'h0, 32'h00000017},
                                {1'b1, 2'b00, 4'h0, 32'h000000C0},
                                39'h0,
                                {1'b1, 2'b00, 4'h0, 32'h00000014},
                                {1'b1, 2'b00, 4'h0, 32'h000000B2}};
        generation  = 3'd1;
        inDataValid = 1'b1;
        inDataK     = 4'h1;
        inData      = 32'hBC;
        #2;
        tests++;
        if (scramblerDataValid !== 1'b0 || scramblerDataOut !== 32'h0) begin
            fails++;
            $display("FAIL gen1_latency: valid %b data %h before edge, want 0 0",
                     scramblerDataValid, scramblerDataOut);
        end
        for (int i = 0; i < 7; i++) begin
            step(vi[i], ki[i], di[i], 1'b0, 2'b00);
            tests++;
            if ({scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut} !== ex[i]) begin
                fails++;
                $display("FAIL gen1_com[%0d]: got %h want %h", i,
                         {scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut}, ex[i]);
            end
        end
    endtask

    task automatic test_gen1_skp();
        logic [3:0]  ki [9] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0};
        logic [7:0]  di [9] = '{8'hBC, 8'h1C, 8'h1C, 8'h1C, 8'h00, 8'hFC, 8'hA5, 8'hBC, 8'h00};
        logic [7:0]  eo [9] = '{8'hBC, 8'h1C, 8'h1C, 8'h1C, 8'hFF, 8'hFC, 8'h65, 8'hBC, 8'hFF};
        logic [38:0] exp_v;
        generation = 3'd1;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, ki[i], {24'h0, di[i]}, 1'b0, 2'b00);
            exp_v = {1'b1, 2'b00, 3'b000, ki[i][0], 24'h0, eo[i]};
            tests++;
            if ({scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut} !== exp_v) begin
                fails++;
                $display("FAIL gen1_skp[%0d]: got %h want %h", i,
                         {scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut}, exp_v);
            end
        end
    endtask

    task automatic test_gen3_skp();
        logic [15:0] d;
        logic [15:0] e;
        logic [38:0] exp_v;
        generation = 3'd3;
        m23        = SEED;
        for (int i = 0; i < 8; i++) begin
            d = (i == 7) ? 16'hE1AA : 16'hAAAA;
            step(1'b1, 4'h0, {(i == 3) ? 16'hFFFF : 16'h0000, d}, i == 0, (i == 0) ? 2'b01 : 2'b00);
            exp_v = {1'b1, 2'b01, 4'h0, 16'h0, d};
            tests++;
            if ({scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut} !== exp_v) begin
                fails++;
                $display("FAIL gen3_skp[%0d]: got %h want %h", i,
                         {scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut}, exp_v);
            end
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 4'hF, 32'h0, i == 0, (i == 0) ? 2'b10 : 2'b11);
            m3_word(16'h0000, 1'b0, e);
            exp_v = {1'b1, 2'b10, 4'h0, 16'h0, e};
            tests++;
            if ({scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut} !== exp_v) begin
                fails++;
                $display("FAIL gen3_data_after_skp[%0d]: got %h want %h", i,
                         {scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut}, exp_v);
            end
        end
    endtask

    task automatic test_gen3_eieos();
        logic [15:0] e;
        logic [38:0] exp_v;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 4'h0, 32'h0000FF00, i == 0, 2'b01);
            exp_v = {1'b1, 2'b01, 4'h0, 32'h0000FF00};
            tests++;
            if ({scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut} !== exp_v) begin
                fails++;
                $display("FAIL gen3_eieos[%0d]: got %h want %h", i,
                         {scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut}, exp_v);
            end
        end
        m23 = SEED;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'h0, 32'h0, i == 0, 2'b10);
            m3_word(16'h0000, 1'b0, e);
            exp_v = {1'b1, 2'b10, 4'h0, 16'h0, e};
            tests++;
            if ({scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut} !== exp_v) begin
                fails++;
                $display("FAIL gen3_data_after_eieos[%0d]: got %h want %h", i,
                         {scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut}, exp_v);
            end
        end
    endtask

    // Continues the data block left at wordCnt=3 by test_gen3_eieos.
    task automatic test_gen3_midblock();
        logic [15:0] e;
        logic [38:0] exp_v;
        step(1'b1, 4'h0, 32'h00000155, 1'b1, 2'b01);
        m3_word(16'h0155, 1'b1, e);
        exp_v = {1'b1, 2'b01, 4'h0, 16'h0, e};
        tests++;
        if ({scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut} !== exp_v) begin
            fails++;
            $display("FAIL midblock_os_start: got %h want %h",
                     {scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut}, exp_v);
        end
        step(1'b1, 4'h0, 32'h0, 1'b0, 2'b10);
        m3_word(16'h0000, 1'b0, e);
        exp_v = {1'b1, 2'b01, 4'h0, 16'h0, e};
        tests++;
        if ({scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut} !== exp_v) begin
            fails++;
            $display("FAIL midblock_os_word1: got %h want %h",
                     {scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut}, exp_v);
        end
        step(1'b1, 4'h0, 32'h00001234, 1'b1, 2'b00);
        exp_v = {1'b1, 2'b00, 4'h0, 32'h00001234};
        tests++;
        if ({scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut} !== exp_v) begin
            fails++;
            $display("FAIL bad_sync_passthru: got %h want %h",
                     {scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut}, exp_v);
        end
        step(1'b1, 4'h0, 32'h00005678, 1'b0, 2'b10);
        exp_v = {1'b1, 2'b00, 4'h0, 32'h00005678};
        tests++;
        if ({scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut} !== exp_v) begin
            fails++;
            $display("FAIL wait_passthru: got %h want %h",
                     {scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut}, exp_v);
        end
        step(1'b1, 4'h0, 32'h0, 1'b1, 2'b10);
        m3_word(16'h0000, 1'b0, e);
        exp_v = {1'b1, 2'b10, 4'h0, 16'h0, e};
        tests++;
        if ({scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut} !== exp_v) begin
            fails++;
            $display("FAIL data_after_wait: got %h want %h",
                     {scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut}, exp_v);
        end
    endtask

    task automatic test_idle_gen();
        generation = 3'd0;
        step(1'b1, 4'h1, 32'h00001234, 1'b1, 2'b10);
        tests++;
        if ({scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut} !== 39'h0) begin
            fails++;
            $display("FAIL idle_generation: got %h want %h",
                     {scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut}, 39'h0);
        end
    endtask

    task automatic test_reset_async();
        logic [15:0] e;
        logic [38:0] exp_v;
        generation = 3'd3;
        m23        = SEED;
        step(1'b1, 4'h0, 32'h0, 1'b1, 2'b10);
        m3_word(16'h0000, 1'b0, e);
        exp_v = {1'b1, 2'b10, 4'h0, 16'h0, e};
        tests++;
        if ({scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut} !== exp_v) begin
            fails++;
            $display("FAIL pre_reset_word: got %h want %h",
                     {scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut}, exp_v);
        end
        inBlockStart = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if ({scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut} !== 39'h0) begin
            fails++;
            $display("FAIL async_reset: got %h want %h",
                     {scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut}, 39'h0);
        end
        @(posedge pclk);
        #1;
        tests++;
        if ({scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut} !== 39'h0) begin
            fails++;
            $display("FAIL reset_held: got %h want %h",
                     {scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut}, 39'h0);
        end
        #2;
        reset      = 1'b0;
        generation = 3'd1;
        step(1'b1, 4'h0, 32'h0, 1'b0, 2'b00);
        exp_v = {1'b1, 2'b00, 4'h0, 32'h000000FF};
        tests++;
        if ({scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut} !== exp_v) begin
            fails++;
            $display("FAIL gen1_after_reset: got %h want %h",
                     {scramblerDataValid, scramblerSyncHeader, scramblerDataK, scramblerDataOut}, exp_v);
        end
    endtask

    initial begin
        reset        = 1'b1;
        generation   = 3'd0;
        inData       = '0;
        inDataK      = '0;
        inSyncHeader = '0;
        inBlockStart = 1'b0;
        inDataValid  = 1'b0;
        m23          = SEED;
        test_reset();
        test_gen1_com();
        test_gen1_skp();
        test_gen3_skp();
        test_gen3_eieos();
        test_gen3_midblock();
        test_idle_gen();
        test_reset_async();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_tx_scrambler.md
Name: pipe_tx_scrambler

Overview:
- Transmit-side scrambler directly upstream of the PIPE data output stage.
- Accepts per-cycle symbols from the framing/ordered-set mux and scrambles them per generation: 8b/10b-era LFSR for Gen1/2, 128b/130b block-aware LFSR for Gen3.
- Drives the scramblerDataOut/DataK/SyncHeader/DataValid bus consumed by the PIPE output stage.
- Per-lane instance; the lane seed is a parameter.

Parameters:
- LANE_SEED, 24'h1DBFBC, Gen3 LFSR seed for this lane (23 LSBs used).
- GEN12_SEED, 16'hFFFF, Gen1/2 LFSR reset value.
- GEN3_WORDS_PER_BLOCK, 8, 16-bit words per 128-bit Gen3 payload.

Ports:
- pclk  in  1  PIPE clock
- reset  in  1  asynchronous, active-high reset
- generation  in  3  1/2/3 selects mode; any other value means idle
- inData  in  32  symbols; byte 0 in [7:0]; Gen1/2 use [7:0], Gen3 uses [15:0]
- inDataK  in  4  K flag per byte; Gen1/2 only
- inSyncHeader  in  2  Gen3 sync header; sampled with inBlockStart
- inBlockStart  in  1  Gen3: first word of a block
- inDataValid  in  1  input qualifier
- scramblerDataOut  out  32  scrambled data
- scramblerDataK  out  4  K flags, passed through
- scramblerSyncHeader  out  2  sync header, registered
- scramblerDataValid  out  1  output qualifier

Behaviour:
- Reset (async, active-high): all outputs 0, LFSR16 = GEN12_SEED, LFSR23 = LANE_SEED[22:0], state = WAIT_BLK, wordCnt = 0.
- Latency: exactly 1 pclk from input to registered output. Valid=0 cycles hold the LFSR and state; outputs show valid=0 and data=0.
- Unused upper data/K bits are driven 0 in every mode.
- generation change: on the first cycle with a new value, both LFSRs reload their seeds and state goes to WAIT_BLK. That cycle's data is processed as if it followed a reset.
- generation not in {1,2,3}: outputs 0, LFSRs held at seed.

Gen1/2, one byte per valid cycle:
- LFSR G(x) = x^16+x^5+x^4+x^3+1, advanced 8 bits per byte.
- Data bit i is XORed with the LFSR output bit for step i, LSB first.
- COM (K=1, 8'hBC): not scrambled; LFSR reloads GEN12_SEED after this byte.
- SKP (K=1, 8'h1C): not scrambled; LFSR does not advance.
- Other K: not scrambled; LFSR advances.
- D bytes: scrambled; LFSR advances.

Gen3, 16 bits (2 bytes) per valid cycle:
- LFSR G(x) = x^23+x^21+x^16+x^8+x^5+x^2+1, advanced 8 per byte, output XOR LSB first.
- FSM states: WAIT_BLK, DATA_BLK, OS_BLK, SKP_BLK, EIEOS_BLK.
- From WAIT_BLK, on valid & inBlockStart:
  - inSyncHeader 2'b10 → DATA_BLK.
  - 2'b01 with byte0 = 8'h00 → EIEOS_BLK.
  - 2'b01 with byte0 = 8'hAA → SKP_BLK.
  - 2'b01 with any other byte0 → OS_BLK.
  - Sync 2'b00 or 2'b11 → WAIT_BLK; data passed unscrambled with header forwarded.
- The state applies to the start word itself.
- DATA_BLK: all bytes scrambled.
- OS_BLK: byte 0 of the block unscrambled, all other bytes scrambled; LFSR advances on every byte.
- SKP_BLK: no scrambling, LFSR frozen. Block ends at wordCnt wrap, or early at the first word after an 8'hE1 byte.
- EIEOS_BLK: no scrambling. LFSR reloads LANE_SEED at block end.
- wordCnt counts 0..GEN3_WORDS_PER_BLOCK-1, then the FSM returns to WAIT_BLK.
- Valid words in WAIT_BLK without inBlockStart: forwarded unscrambled, LFSR frozen.
- inBlockStart mid-block: the current block is abandoned, the new block is decoded, and wordCnt restarts at 0. If the abandoned block was EIEOS, the LFSR reload is still applied first.
- scramblerSyncHeader is updated only on block-start words and holds its value otherwise.

Optional Feature:
- Macro: SCRAMBLER_BYPASS_EN.
- When defined:
  - Adds input port scrambleDisable (1 bit).
  - When high, data passes through unscrambled.
  - LFSR advance/reload rules still apply, so re-enabling stays in sync with the link partner.
- When not defined: no port is added and scrambling is always active.

Test Plan:
- Gen1: COM (8'hBC,K) then data 8'h00, 8'h00 → outputs 8'hBC K=1, then 8'hFF, 8'h17; latency 1 cycle.
- Gen1: COM, SKP×3, then 8'h00 → SKP bytes 8'h1C unchanged; following data 8'hFF (LFSR frozen across SKP).
- Gen3: 8-word SKP block (sync 01, 16'hAAAA ×7, 16'hE1AA) → data bit-identical on output; the next data block's first word matches the scrambled value for an LFSR still at its pre-SKP state.
- Gen3: EIEOS block (16'hFF00 ×8) then data block of 16'h0000 → EIEOS unchanged; data equals the model output for LFSR seeded with 24'h1DBFBC.
- Gen3: inBlockStart asserted at wordCnt=3 of a data block → new block decoded immediately; no valid cycle dropped; sync header updates on that cycle.
- Reset asserted mid-block for 1 cycle → outputs 0 asynchronously; after release the first Gen1 data 8'h00 (with no COM) yields 8'hFF.
